// File: rtl/jtvigil_palwr_if.sv
// Bus bundle for the palette write engine: CPU write port, blanking, and RAM write port.
// The slave modport is the engine's view; the master modport is the driver/observer's view.
interface jtvigil_palwr_if;
  logic        cpu_cen;
  logic [10:0] main_addr;
  logic [7:0]  main_dout;
  logic        main_rnw;
  logic        pal_cs;
  logic        LHBL;
  logic        LVBL;
  logic        main_wait;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        busy;

  modport slave (
    input  cpu_cen, main_addr, main_dout, main_rnw, pal_cs, LHBL, LVBL,
    output main_wait, ram_addr, ram_din, ram_we, busy
  );

  modport master (
    output cpu_cen, main_addr, main_dout, main_rnw, pal_cs, LHBL, LVBL,
    input  main_wait, ram_addr, ram_din, ram_we, busy
  );
endinterface

// File: rtl/jtvigil_palwr.sv
// Palette RAM write engine: clears all 2048 bytes after reset, then drains CPU writes from a FIFO.
// Define JTVIGIL_PALWR_BLANK_EN to restrict commits to horizontal/vertical blanking.
module jtvigil_palwr #(
  parameter int unsigned FIFO_AW = 2,
  parameter logic [7:0]  CLR_VAL = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  jtvigil_palwr_if.slave bus
);

  localparam int unsigned        DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              state_q, state_d;
  logic [10:0]         clr_cnt_q, clr_cnt_d;
  logic [18:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0]  rd_q, wr_q;
  logic [FIFO_AW:0]    level_q, level_d;
  logic [10:0]         ram_addr_q, ram_addr_d;
  logic [7:0]          ram_din_q, ram_din_d;
  logic                ram_we_q, ram_we_d;

  logic full, empty, wr_req, commit_ok, push, pop;

  assign full   = (level_q == LVL_FULL);
  assign empty  = (level_q == '0);
  assign wr_req = bus.pal_cs & ~bus.main_rnw;

`ifdef JTVIGIL_PALWR_BLANK_EN
  assign commit_ok = ~bus.LHBL | ~bus.LVBL;
`else
  logic unused_blank;
  assign unused_blank = bus.LHBL ^ bus.LVBL;
  assign commit_ok    = 1'b1;
`endif

  // full comes from the registered level, so a same-cycle pop never frees the slot for a push
  assign push = (state_q == StRun) & bus.cpu_cen & wr_req & ~full;
  assign pop  = (state_q == StRun) & ~empty & commit_ok;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    level_d    = level_q;
    if (push && !pop) level_d = level_q + LVL_ONE;
    if (pop && !push) level_d = level_q - LVL_ONE;
    unique case (state_q)
      StClear: begin
        ram_we_d   = 1'b1;
        ram_addr_d = clr_cnt_q;
        ram_din_d  = CLR_VAL;
        clr_cnt_d  = clr_cnt_q + 11'd1;
        if (clr_cnt_q == 11'h7ff) state_d = StRun;
      end
      StRun: begin
        if (pop) begin
          ram_we_d                = 1'b1;
          {ram_addr_d, ram_din_d} = mem_q[rd_q];
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      level_q    <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      level_q    <= level_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      if (push) wr_q <= wr_q + PTR_ONE;
      if (pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_q] <= {bus.main_addr, bus.main_dout};
  end

  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.busy      = rst | (state_q == StClear) | ~empty;
  // Writes stall for the whole clear; afterwards only when the FIFO is full
  assign bus.main_wait = ~rst & wr_req & ((state_q == StClear) | full);

endmodule
